fifo_rd_stream: RTL and testbench
=================================

FIFO_RD_STREAM -- requirements
Module: fifo_rd_stream

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, the data word width in bits.
REQ-002 The block SHALL have port i_clk, input, 1, the single clock, which is the read clock of the upstream async FIFO.
REQ-003 The block SHALL have port i_rst, input, 1, reset; one clock; reset is asynchronous and active-high.
REQ-004 The block SHALL have port i_fifo_empty, input, 1, the upstream FIFO empty flag.
REQ-005 The block SHALL have port o_fifo_pop, output, 1, the pop request to the upstream FIFO.
REQ-006 The block SHALL have port i_fifo_rdata, input, WIDTH, the upstream read data, valid in the cycle after a pop.
REQ-007 The block SHALL have port o_valid, output, 1, which marks downstream data as valid.
REQ-008 The block SHALL have port i_ready, input, 1, the downstream ready.
REQ-009 The block SHALL have port o_data, output, WIDTH, the downstream data (head of buffer).
REQ-010 The block SHALL have port o_level, output, 2, the buffer occupancy (0..2).

Function
REQ-011 The block SHALL convert the FIFO pop/empty/1-cycle-latency read interface into a valid/ready stream using a 2-entry register buffer.
REQ-012 The block SHALL hold an in-flight flag, a 1-bit register equal to o_fifo_pop of the previous cycle.
REQ-013 o_fifo_pop SHALL equal !i_fifo_empty && (occ + inflight - drain) < 2, with drain = o_valid && i_ready and 3-bit arithmetic (no underflow: drain implies occ >= 1).
REQ-014 When the in-flight flag is 1, the block SHALL write i_fifo_rdata into the buffer tail in that cycle.
REQ-015 The buffer SHALL be a circular 2-entry store with 1-bit write and read indices that wrap 1->0.
REQ-016 o_valid SHALL be registered, and SHALL equal (occ != 0).
REQ-017 o_data SHALL be the entry at the read index.
REQ-018 A transfer SHALL occur only on o_valid && i_ready; the read index SHALL advance and occ SHALL decrement on a transfer.
REQ-019 Simultaneous write and transfer SHALL leave occ unchanged and SHALL advance both indices.
REQ-020 Latency SHALL be: pop asserted in cycle N, data captured at the end of N+1, o_valid=1 in N+2 for an empty buffer.
REQ-021 Throughput SHALL be 1 word/cycle sustained with i_ready held high and the FIFO non-empty.
REQ-022 While o_valid=1 and i_ready=0, o_data and o_valid SHALL hold stable (no drop, no overwrite).
REQ-023 The buffer SHALL never overflow: occ + inflight <= 2 at every clock edge.
REQ-024 o_level SHALL equal occ.
REQ-025 Word order SHALL equal FIFO pop order.
REQ-026 i_fifo_empty deasserting mid-stream SHALL resume popping in the same cycle without bubbles beyond REQ-020.

Reset
REQ-027 On i_rst=1 (asynchronous), the block SHALL clear occ, both indices, the in-flight flag and o_valid to 0, and SHALL clear buffer entries and o_data to 0.
REQ-028 o_fifo_pop SHALL be 0 while i_rst=1.
REQ-029 A reset asserted while a pop is in flight SHALL discard that word; this loss is specified behaviour and upstream FIFO read-side reset is the system's responsibility.
REQ-030 Release of reset SHALL occur synchronously to i_clk upstream of this block; the first pop SHALL be possible in the first cycle after release.

Structure
REQ-031 Shared package fifo_pkg SHALL hold the localparam SKID_DEPTH=2 and the occupancy width constant LVL_W=2.
REQ-032 One sub-module, skid_buf2, SHALL implement the 2-entry buffer (write, read, indices, occ).
REQ-033 The top level SHALL contain only the pop-credit logic and the in-flight flag.
REQ-034 RTL size SHALL be 120-400 lines total.

Verification
REQ-035 Reset, i_fifo_empty=0, i_ready=1, FIFO words 0x0001..0x0008 -> pop in cycle 1, o_valid in cycle 3, 0x0001..0x0008 delivered on consecutive cycles, o_level=1 steady.
REQ-036 i_ready=0, 5 words available -> exactly 2 pops, o_level=2, o_data=0x0001 held stable, no further pops; raising i_ready -> 0x0001,0x0002,0x0003 in order, no gaps.
REQ-037 i_fifo_empty toggled every other cycle with words 0xA0..0xA3 -> all four delivered in order, pops only while empty=0.
REQ-038 i_ready random 50%, 64 sequential words -> scoreboard exact order and no loss; assertion occ+inflight<=2 and no pop while empty=1 every cycle.
REQ-039 i_rst asserted the cycle after a pop with o_level=1 -> o_valid=0, o_level=0, o_fifo_pop=0 immediately (asynchronous); after release, the next word 0x0055 is delivered 2 cycles after its pop.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared sizing constants for the FIFO read-side stream adapter.
package fifo_pkg;
    localparam int SKID_DEPTH = 2;
    localparam int LVL_W      = 2;
endpackage

// File: rtl/skid_buf2.sv
// Two-entry circular register buffer: tail written on i_wr_vld, head popped on valid&&ready.
// Latency: write at edge N, o_rd_vld high from N+1; backpressure: holds head stable while !i_rd_rdy.
module skid_buf2
    import fifo_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_wr_vld,
    input  logic [WIDTH-1:0] i_wr_dat,
    output logic             o_rd_vld,
    input  logic             i_rd_rdy,
    output logic [WIDTH-1:0] o_rd_dat,
    output logic [LVL_W-1:0] o_occ
);

    logic [WIDTH-1:0] r_mem [SKID_DEPTH];
    logic             r_wr_idx;
    logic             r_rd_idx;
    logic [LVL_W-1:0] r_occ;
    logic             r_vld;

    logic             w_rd_fire;
    logic [LVL_W-1:0] w_occ_nxt;

    assign w_rd_fire = r_vld && i_rd_rdy;

    always_comb begin
        w_occ_nxt = r_occ;
        case ({i_wr_vld, w_rd_fire})
            2'b10:   w_occ_nxt = r_occ + 2'd1;
            2'b01:   w_occ_nxt = r_occ - 2'd1;
            default: w_occ_nxt = r_occ;
        endcase
    end

    // Valid is registered from the next occupancy so it always equals (occ != 0).
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < SKID_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_idx <= 1'b0;
            r_rd_idx <= 1'b0;
            r_occ    <= '0;
            r_vld    <= 1'b0;
        end else begin
            if (i_wr_vld) begin
                r_mem[r_wr_idx] <= i_wr_dat;
                r_wr_idx        <= r_wr_idx + 1'b1;
            end
            if (w_rd_fire) begin
                r_rd_idx <= r_rd_idx + 1'b1;
            end
            r_occ <= w_occ_nxt;
            r_vld <= (w_occ_nxt != '0);
        end
    end

    assign o_rd_vld = r_vld;
    assign o_rd_dat = r_mem[r_rd_idx];
    assign o_occ    = r_occ;

endmodule

// File: rtl/fifo_rd_stream.sv
// Turns a pop/empty FIFO read port (1-cycle read latency) into a valid/ready stream.
// Latency: pop in N, o_valid in N+2; backpressure: pops only while buffer credit remains, no drops.
module fifo_rd_stream
    import fifo_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_fifo_empty,
    output logic             o_fifo_pop,
    input  logic [WIDTH-1:0] i_fifo_rdata,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_data,
    output logic [LVL_W-1:0] o_level
);

    logic       r_inflight;
    logic       w_drain;
    logic [2:0] w_credit_sum;
    logic       w_pop;

    assign w_drain      = o_valid && i_ready;
    // A drain implies occ >= 1, so this 3-bit sum never underflows.
    assign w_credit_sum = 3'(o_level) + {2'b00, r_inflight} - {2'b00, w_drain};
    assign w_pop        = !i_rst && !i_fifo_empty && (w_credit_sum < 3'(SKID_DEPTH));
    assign o_fifo_pop   = w_pop;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= w_pop;
        end
    end

    skid_buf2 #(
        .WIDTH (WIDTH)
    ) u_buf (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_wr_vld (r_inflight),
        .i_wr_dat (i_fifo_rdata),
        .o_rd_vld (o_valid),
        .i_rd_rdy (i_ready),
        .o_rd_dat (o_data),
        .o_occ    (o_level)
    );

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Randomised and directed bench for fifo_rd_stream against a queue-based reference model.
module tb_fifo_rd_stream;
    localparam int W = 16;

    logic         i_clk = 1'b0;
    logic         i_rst = 1'b1;
    logic         i_fifo_empty = 1'b1;
    logic         o_fifo_pop;
    logic [W-1:0] i_fifo_rdata = '0;
    logic         o_valid;
    logic         i_ready = 1'b0;
    logic [W-1:0] o_data;
    logic [1:0]   o_level;

    fifo_rd_stream #(.WIDTH(W)) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_fifo_empty (i_fifo_empty),
        .o_fifo_pop   (o_fifo_pop),
        .i_fifo_rdata (i_fifo_rdata),
        .o_valid      (o_valid),
        .i_ready      (i_ready),
        .o_data       (o_data),
        .o_level      (o_level)
    );

    always #5 i_clk = ~i_clk;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    logic [W-1:0] mbuf[$];
    bit           m_infl;
    logic [W-1:0] fifo_q[$];
    logic [W-1:0] exp_q[$];

    int n_pops, n_deliv, first_pop_cyc, first_vld_cyc, first_deliv_cyc, last_deliv_cyc;
    int lvl_hist[64];
    int dat_hist[64];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        n_chk++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp_v, cyc);
        end
    endtask

    task automatic load(input logic [W-1:0] w);
        fifo_q.push_back(w);
        exp_q.push_back(w);
    endtask

    task automatic rst_assert();
        i_ready      = 1'b1;
        i_fifo_empty = 1'b0;
        i_rst        = 1'b1;
        #1;
        chk("rst_pop",   o_fifo_pop, 0);
        chk("rst_valid", o_valid,    0);
        chk("rst_level", o_level,    0);
        chk("rst_data",  o_data,     0);
        mbuf.delete();
        m_infl = 1'b0;
        fifo_q.delete();
        exp_q.delete();
    endtask

    task automatic release_rst(input bit nrdy);
        @(posedge i_clk);
        #1;
        i_rst        = 1'b0;
        i_ready      = nrdy;
        i_fifo_empty = (fifo_q.size() == 0);
        i_fifo_rdata = W'($urandom);
        cyc = 1;
        n_pops = 0;
        n_deliv = 0;
        first_pop_cyc = -1;
        first_vld_cyc = -1;
        first_deliv_cyc = -1;
        last_deliv_cyc = -1;
        for (int i = 0; i < 64; i++) begin
            lvl_hist[i] = -1;
            dat_hist[i] = -1;
        end
    endtask

    // One clock cycle: compare against the model mid-cycle, then advance model and stimulus.
    task automatic step(input bit nrdy, input bit ngate);
        int msz;
        bit edrn, epop, pop;
        @(negedge i_clk);
        msz  = mbuf.size();
        edrn = (msz != 0) && i_ready;
        epop = !i_fifo_empty && ((msz + int'(m_infl) - int'(edrn)) < 2);
        chk("pop",   o_fifo_pop, epop);
        chk("valid", o_valid,    (msz != 0));
        chk("level", o_level,    msz);
        if (msz != 0) chk("data", o_data, mbuf[0]);
        chk("pop_while_empty", (i_fifo_empty && o_fifo_pop), 0);
        chk("no_overflow", ((int'(o_level) + int'(m_infl)) <= 2), 1);
        if (cyc < 64) begin
            lvl_hist[cyc] = o_level;
            dat_hist[cyc] = o_data;
        end
        pop = o_fifo_pop;
        if (o_valid && i_ready) begin
            n_deliv++;
            if (first_deliv_cyc < 0) first_deliv_cyc = cyc;
            last_deliv_cyc = cyc;
            if (exp_q.size() == 0) chk("extra_word", o_data, 32'hFFFF_FFFF);
            else chk("order", o_data, exp_q.pop_front());
        end
        if (pop) begin
            n_pops++;
            if (first_pop_cyc < 0) first_pop_cyc = cyc;
        end
        if (o_valid && first_vld_cyc < 0) first_vld_cyc = cyc;
        @(posedge i_clk);
        if (edrn) void'(mbuf.pop_front());
        if (m_infl) mbuf.push_back(i_fifo_rdata);
        m_infl = pop;
        #1;
        if (pop && fifo_q.size() != 0) i_fifo_rdata = fifo_q.pop_front();
        else i_fifo_rdata = W'($urandom);
        i_ready      = nrdy;
        i_fifo_empty = (fifo_q.size() == 0) || ngate;
        cyc++;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        // Sustained streaming of 8 words with ready held high.
        #2;
        rst_assert();
        for (int i = 1; i <= 8; i++) load(W'(i));
        release_rst(1'b1);
        repeat (12) step(1'b1, 1'b0);
        chk("t1_first_pop",   first_pop_cyc, 1);
        chk("t1_first_valid", first_vld_cyc, 3);
        for (int c = 3; c <= 10; c++) chk("t1_level_steady", lvl_hist[c], 1);
        chk("t1_n_deliv",     n_deliv, 8);
        chk("t1_first_deliv", first_deliv_cyc, 3);
        chk("t1_last_deliv",  last_deliv_cyc, 10);

        // Backpressure: only two pops, head held, then drain without gaps.
        rst_assert();
        for (int i = 1; i <= 5; i++) load(W'(i));
        release_rst(1'b0);
        for (int k = 1; k <= 6; k++) step(k == 6, 1'b0);
        chk("t2_n_pops", n_pops, 2);
        chk("t2_level",  o_level, 2);
        chk("t2_data",   o_data, 16'h0001);
        chk("t2_lvl5",   lvl_hist[5], 2);
        for (int c = 3; c <= 6; c++) chk("t2_data_held", dat_hist[c], 16'h0001);
        repeat (3) step(1'b1, 1'b0);
        chk("t2_n_deliv",     n_deliv, 3);
        chk("t2_first_deliv", first_deliv_cyc, 7);
        chk("t2_last_deliv",  last_deliv_cyc, 9);

        // Empty flag toggling every other cycle.
        rst_assert();
        for (int i = 0; i < 4; i++) load(W'(16'h00A0 + i));
        release_rst(1'b1);
        for (int k = 1; k <= 20; k++) step(1'b1, (k % 2) == 1);
        chk("t3_n_deliv", n_deliv, 4);
        chk("t3_left",    exp_q.size(), 0);

        // Random ready (and occasional empty gating) over 64 sequential words.
        rst_assert();
        for (int i = 0; i < 64; i++) load(W'(16'h0100 + i));
        release_rst(1'($urandom_range(0, 1)));
        for (int k = 0; k < 2000 && n_deliv < 64; k++)
            step(1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
        chk("t4_n_deliv", n_deliv, 64);
        chk("t4_left",    exp_q.size(), 0);

        // Asynchronous reset with a word in flight, then a fresh word after release.
        rst_assert();
        for (int i = 0; i < 16; i++) load(W'(16'h0010 + i));
        release_rst(1'b1);
        repeat (4) step(1'b1, 1'b0);
        chk("t5_pre_level", o_level, 1);
        chk("t5_pre_pops",  n_pops, 4);
        #2;
        rst_assert();
        load(16'h0055);
        release_rst(1'b1);
        repeat (4) step(1'b1, 1'b0);
        chk("t5_first_pop",   first_pop_cyc, 1);
        chk("t5_first_valid", first_vld_cyc, 3);
        chk("t5_deliv_cyc",   first_deliv_cyc, 3);
        chk("t5_data",        dat_hist[3], 16'h0055);
        chk("t5_n_deliv",     n_deliv, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
